// File: rtl/bsk_com_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsk_com_filter                                                |
// | Purpose  : Input qualifier for the 16 BSK command lines. Each raw line   |
// |            is synchronised (2 flops), debounced by a per-channel         |
// |            STABLE/QUALIFY FSM and registered onto oCom. A one-cycle      |
// |            per-channel change mask (and its OR) marks every update.      |
// | Option   : define BSK_COM_HOLD_EN to add a per-channel minimum hold of    |
// |            HOLD_CNT cycles after each oCom update.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bsk_com_filter #(
   parameter int CH_NUM   = 16,
   parameter int DEB_CNT  = 20,
   parameter int HOLD_CNT = 40
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic [CH_NUM-1:0] iComRaw,
   input  logic              iFreeze,
   output logic [CH_NUM-1:0] oCom,
   output logic [CH_NUM-1:0] oChangeMask,
   output logic              oChange
);

   localparam int                 C_CNT_W   = $clog2(DEB_CNT + 1);
   localparam logic [C_CNT_W-1:0] C_DEB_MAX = C_CNT_W'(DEB_CNT);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

   typedef enum logic [0:0] {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } state_t;

   logic [CH_NUM-1:0] r_sync1;
   logic [CH_NUM-1:0] r_sync2;

   // Two-flop synchroniser; the only logic that touches the raw lines.
   // It keeps sampling during iFreeze so s2 is current at release.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= iComRaw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      state_t             r_state;
      state_t             w_state_nxt;
      logic [C_CNT_W-1:0] r_cnt;
      logic [C_CNT_W-1:0] w_cnt_nxt;
      logic               r_com;
      logic               w_com_nxt;
      logic               r_mask;
      logic               w_mask_nxt;
      logic               w_hold_busy;

`ifdef BSK_COM_HOLD_EN
      localparam int                  C_HOLD_W   = $clog2(HOLD_CNT + 1);
      localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(HOLD_CNT);
      localparam logic [C_HOLD_W-1:0] C_HOLD_ONE = C_HOLD_W'(1);

      logic [C_HOLD_W-1:0] r_hold;
      logic [C_HOLD_W-1:0] w_hold_nxt;

      assign w_hold_busy = (r_hold != '0);

      // Hold counter: reload on every update, count down while not frozen.
      always_comb begin
         w_hold_nxt = r_hold;
         if (!iFreeze) begin
            if (w_mask_nxt) begin
               w_hold_nxt = C_HOLD_MAX;
            end else if (w_hold_busy) begin
               w_hold_nxt = r_hold - C_HOLD_ONE;
            end
         end
      end

      // Hold counter register.
      always_ff @(posedge clk or posedge aclr) begin
         if (aclr) begin
            r_hold <= '0;
         end else begin
            r_hold <= w_hold_nxt;
         end
      end
`else
      // Hold feature not built: the channel is never held, HOLD_CNT has no
      // effect (the expression below is constant 0 for any legal HOLD_CNT).
      assign w_hold_busy = (HOLD_CNT < 0);
`endif

      // Debounce FSM: a mismatch between s2 and oCom must persist through
      // DEB_CNT+1 consecutive evaluations before oCom follows s2.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_com_nxt   = r_com;
         w_mask_nxt  = 1'b0;
         if (!iFreeze) begin
            if (w_hold_busy) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end else begin
               case (r_state)
                  ST_STABLE: begin
                     if (r_sync2[g] != r_com) begin
                        w_state_nxt = ST_QUALIFY;
                        w_cnt_nxt   = C_CNT_ONE;
                     end else begin
                        w_cnt_nxt   = '0;
                     end
                  end
                  ST_QUALIFY: begin
                     if (r_sync2[g] == r_com) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                     end else if (r_cnt == C_DEB_MAX) begin
                        w_com_nxt   = r_sync2[g];
                        w_mask_nxt  = 1'b1;
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                     end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                     end
                  end
                  default: begin
                     w_state_nxt = ST_STABLE;
                     w_cnt_nxt   = '0;
                  end
               endcase
            end
         end
      end

      // Per-channel state, counter, qualified output and change flag.
      always_ff @(posedge clk or posedge aclr) begin
         if (aclr) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_com   <= 1'b0;
            r_mask  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_com   <= w_com_nxt;
            r_mask  <= w_mask_nxt;
         end
      end

      assign oCom[g]        = r_com;
      assign oChangeMask[g] = r_mask;
   end

   assign oChange = |oChangeMask;

endmodule
`default_nettype wire

// File: tb/tb_bsk_com_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bsk_com_filter                                             |
// | Purpose  : Self-checking bench for bsk_com_filter (DEB_CNT=4,            |
// |            HOLD_CNT=8). A run-length reference model is compared every   |
// |            cycle; directed steps pin hand-computed values.               |
// |            Honours BSK_COM_HOLD_EN when defined.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bsk_com_filter;

   localparam int C_DEB  = 4;
   localparam int C_HOLD = 8;

   logic        clk;
   logic        aclr;
   logic [15:0] iComRaw;
   logic        iFreeze;
   logic [15:0] oCom;
   logic [15:0] oChangeMask;
   logic        oChange;

   int n_checks = 0;
   int n_errors = 0;

   bsk_com_filter #(
      .CH_NUM   (16),
      .DEB_CNT  (C_DEB),
      .HOLD_CNT (C_HOLD)
   ) dut (
      .clk         (clk),
      .aclr        (aclr),
      .iComRaw     (iComRaw),
      .iFreeze     (iFreeze),
      .oCom        (oCom),
      .oChangeMask (oChangeMask),
      .oChange     (oChange)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per channel, count consecutive evaluations where the
   // synchronised level differs from the output; accept at DEB_CNT+1.
   typedef struct packed {
      logic [15:0]      com;
      logic [15:0]      mask;
      logic [15:0][7:0] run;
      logic [15:0][7:0] hold;
   } mstate_t;

   mstate_t     m;
   logic [15:0] m_s1;
   logic [15:0] m_s2;

   function automatic mstate_t model_step(input mstate_t cur, input logic [15:0] s2,
                                          input logic frz);
      mstate_t n;
      n      = cur;
      n.mask = '0;
      if (!frz) begin
         for (int ch = 0; ch < 16; ch++) begin
            if (n.hold[ch] != 8'd0) begin
               n.hold[ch] = n.hold[ch] - 8'd1;
               n.run[ch]  = 8'd0;
            end else if (s2[ch] != n.com[ch]) begin
               n.run[ch] = n.run[ch] + 8'd1;
               if (n.run[ch] == 8'(C_DEB + 1)) begin
                  n.com[ch]  = s2[ch];
                  n.mask[ch] = 1'b1;
                  n.run[ch]  = 8'd0;
`ifdef BSK_COM_HOLD_EN
                  n.hold[ch] = 8'(C_HOLD);
`endif
               end
            end else begin
               n.run[ch] = 8'd0;
            end
         end
      end
      return n;
   endfunction

   // Model state update, reset asynchronously like the design.
   always @(posedge clk or posedge aclr) begin
      if (aclr) begin
         m    <= '0;
         m_s1 <= '0;
         m_s2 <= '0;
      end else begin
         m    <= model_step(m, m_s2, iFreeze);
         m_s1 <= iComRaw;
         m_s2 <= m_s1;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, just after each edge.
   always @(posedge clk) begin
      #1;
      check("model oCom", oCom, m.com);
      check("model oChangeMask", oChangeMask, m.mask);
      check("model oChange", {15'd0, oChange}, {15'd0, |m.mask});
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   int n_chg;

   initial begin
      aclr    = 1'b1;
      iComRaw = 16'hFFFF;
      iFreeze = 1'b0;

      // 1. Reset holds everything low even with all raw lines high.
      for (int i = 0; i < 4; i++) begin
         wait_neg(1);
         check("reset oCom", oCom, 16'h0000);
         check("reset oChange", {15'd0, oChange}, 16'h0000);
      end
      iComRaw = 16'h0000;
      wait_neg(1);
      aclr = 1'b0;
      wait_neg(2);

      // 2. Clean step on bit3: update on the 7th edge, one-cycle mask.
      iComRaw = 16'h0008;
      wait_neg(6);
      check("step bit3 edge6", oCom, 16'h0000);
      wait_neg(1);
      check("step bit3 edge7 oCom", oCom, 16'h0008);
      check("step bit3 mask", oChangeMask, 16'h0008);
      wait_neg(1);
      check("step bit3 mask clear", oChangeMask, 16'h0000);
      check("step bit3 oChange clear", {15'd0, oChange}, 16'h0000);

      // 3. Four-cycle pulse on bit5 is rejected.
      iComRaw = 16'h0028;
      wait_neg(4);
      iComRaw = 16'h0008;
      n_chg = 0;
      for (int i = 0; i < 12; i++) begin
         wait_neg(1);
         if (oChange) n_chg++;
      end
      check("pulse bit5 oChange count", 16'(n_chg), 16'h0000);
      check("pulse bit5 oCom", oCom, 16'h0008);

      // 4. Bits 0 and 15 together.
      iComRaw = 16'h8009;
      wait_neg(6);
      check("dual edge6", oCom, 16'h0008);
      wait_neg(1);
      check("dual mask", oChangeMask, 16'h8001);
      check("dual oCom", oCom, 16'h8009);

      // 5a. Freeze bit7 mid-count for 10 cycles, then finish remaining count.
      iComRaw = 16'h8089;
      wait_neg(3);
      iFreeze = 1'b1;
      wait_neg(10);
      check("freeze bit7 held", oCom, 16'h8009);
      iFreeze = 1'b0;
      wait_neg(3);
      check("freeze bit7 rel+3", oCom, 16'h8009);
      wait_neg(1);
      check("freeze bit7 rel+4", oCom, 16'h8089);
      check("freeze bit7 mask", oChangeMask, 16'h0080);

      // 5b. Freeze rising on the acceptance edge of bit11 suppresses it.
      iComRaw = 16'h8889;
      wait_neg(6);
      iFreeze = 1'b1;
      wait_neg(2);
      check("freeze accept oCom", oCom, 16'h8089);
      check("freeze accept oChange", {15'd0, oChange}, 16'h0000);
      iFreeze = 1'b0;
      wait_neg(1);
      check("freeze accept release", oCom, 16'h8889);
      check("freeze accept mask", oChangeMask, 16'h0800);

      // 5c. Reset mid-count on bit9 discards the count.
      iComRaw = 16'h8A89;
      wait_neg(4);
      aclr = 1'b1;
      #1;
      check("aclr mid oCom", oCom, 16'h0000);
      check("aclr mid mask", oChangeMask, 16'h0000);
      iComRaw = 16'h0200;
      wait_neg(2);
      aclr = 1'b0;
      wait_neg(6);
      check("post aclr edge6", oCom, 16'h0000);
      wait_neg(1);
      check("post aclr edge7", oCom, 16'h0200);

      // 6. Bit2 qualifies to 1, raw drops one cycle after.
      iComRaw = 16'h0204;
      wait_neg(7);
      check("hold bit2 set", oCom, 16'h0204);
      wait_neg(1);
      iComRaw = 16'h0200;
`ifdef BSK_COM_HOLD_EN
      wait_neg(7);
      check("hold bit2 at U+8", oCom, 16'h0204);
      wait_neg(4);
      check("hold bit2 at U+12", oCom, 16'h0204);
      wait_neg(1);
      check("hold bit2 at U+13", oCom, 16'h0200);
`else
      wait_neg(6);
      check("nohold bit2 at U+7", oCom, 16'h0204);
      wait_neg(1);
      check("nohold bit2 at U+8", oCom, 16'h0200);
`endif
      wait_neg(12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
